// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared exception codes, FSM states, event kinds and vector address
package exc_pkg;

    typedef enum logic [4:0] {
        INT  = 5'd0,
        ADEL = 5'd4,
        ADES = 5'd5,
        SYS  = 5'd8,
        BP   = 5'd9,
        RI   = 5'd10,
        OV   = 5'd12
    } exc_code_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT
    } exc_state_t;

    // Kind selects where BadVAddr comes from, or marks an ERET return
    typedef enum logic [1:0] {
        K_PLAIN,
        K_BADV_PC,
        K_BADV_MEM,
        K_ERET
    } exc_kind_t;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

endpackage

// File: rtl/exc_priority_enc.sv
// rtl/exc_priority_enc.sv - combinational priority select of interrupt, exceptions and ERET
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic [6:0] exc_flags,
    input  logic       int_pending,
    input  logic       is_eret,
    output logic       valid,
    output exc_code_t  code,
    output exc_kind_t  kind
);

    // exc_flags = {adel_if, ri, ov, sys, bp, adel_ld, ades}
    always_comb begin
        valid = 1'b1;
        code  = INT;
        kind  = K_PLAIN;
        if (int_pending) begin
            code = INT;
        end else if (exc_flags[6]) begin
            code = ADEL;
            kind = K_BADV_PC;
        end else if (exc_flags[5]) begin
            code = RI;
        end else if (exc_flags[4]) begin
            code = OV;
        end else if (exc_flags[3]) begin
            code = SYS;
        end else if (exc_flags[2]) begin
            code = BP;
        end else if (exc_flags[1]) begin
            code = ADEL;
            kind = K_BADV_MEM;
        end else if (exc_flags[0]) begin
            code = ADES;
            kind = K_BADV_MEM;
        end else if (is_eret) begin
            kind = K_ERET;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - exception commit FSM (IDLE/FLUSH/REDIRECT); EXCEPTION_UNIT_PERF_COUNT_EN adds exc_count
module exception_unit
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic [6:0]  exc_flags,
    input  logic        is_eret,
    input  logic [31:0] mem_addr,
    input  logic        mem_stall,
    input  logic        allow_interrupt,
    input  logic [7:0]  interrupt_flag,
    input  logic [31:0] epc_address,
    output logic        exp_en,
    output logic        exp_badvaddr_en,
    output logic        exp_bd,
    output logic        exl_clean,
    output logic [4:0]  exp_code,
    output logic [31:0] exp_badvaddr,
    output logic [31:0] exp_epc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] exc_count
);

    exc_state_t  state, state_next;
    logic        int_pending;
    logic        detect;

    logic        enc_valid;
    exc_code_t   enc_code;
    exc_kind_t   enc_kind;

    exc_code_t   cap_code;
    logic        cap_eret;
    logic        cap_bd;
    logic        cap_badv_en;
    logic [31:0] cap_badv;
    logic [31:0] cap_epc;

    logic        in_flush;
    logic        in_redir;

    exc_priority_enc u_enc (
        .exc_flags   (exc_flags),
        .int_pending (int_pending),
        .is_eret     (is_eret),
        .valid       (enc_valid),
        .code        (enc_code),
        .kind        (enc_kind)
    );

    always_comb begin
        state_next = state;
        detect     = 1'b0;
        case (state)
            S_IDLE: begin
                if (commit_valid && !mem_stall && enc_valid) begin
                    detect     = 1'b1;
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!mem_stall) state_next = S_REDIRECT;
            end
            S_REDIRECT: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            int_pending <= 1'b0;
            cap_code    <= INT;
            cap_eret    <= 1'b0;
            cap_bd      <= 1'b0;
            cap_badv_en <= 1'b0;
            cap_badv    <= 32'd0;
            cap_epc     <= 32'd0;
        end else begin
            state       <= state_next;
            int_pending <= allow_interrupt && (|interrupt_flag);
            if (detect) begin
                cap_code    <= enc_code;
                cap_eret    <= (enc_kind == K_ERET);
                cap_bd      <= (enc_kind == K_ERET) ? 1'b0 : commit_bd;
                cap_badv_en <= (enc_kind == K_BADV_PC) || (enc_kind == K_BADV_MEM);
                cap_badv    <= (enc_kind == K_BADV_PC)  ? commit_pc :
                               (enc_kind == K_BADV_MEM) ? mem_addr  : 32'd0;
                // ERET returns to CP0's EPC; delay-slot faults restart at the branch
                cap_epc     <= (enc_kind == K_ERET) ? epc_address :
                               (commit_bd ? commit_pc - 32'd4 : commit_pc);
            end
        end
    end

    assign in_flush = (state == S_FLUSH);
    assign in_redir = (state == S_REDIRECT);

    assign exp_en          = in_flush;
    assign exp_code        = in_flush ? cap_code    : 5'd0;
    assign exp_bd          = in_flush ? cap_bd      : 1'b0;
    assign exl_clean       = in_flush ? cap_eret    : 1'b0;
    assign exp_badvaddr_en = in_flush ? cap_badv_en : 1'b0;
    assign exp_badvaddr    = in_flush ? cap_badv    : 32'd0;
    assign exp_epc         = in_flush ? cap_epc     : 32'd0;

    assign flush          = in_flush || in_redir;
    assign redirect_valid = in_redir;
    assign redirect_pc    = in_redir ? (cap_eret ? cap_epc : EXC_VECTOR) : 32'd0;

`ifdef EXCEPTION_UNIT_PERF_COUNT_EN
    logic [31:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 32'd0;
        end else if (in_flush && !mem_stall && !cap_eret) begin
            count <= count + 32'd1;
        end
    end

    assign exc_count = count;
`else
    assign exc_count = 32'd0;
`endif

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port commit_valid, input, 1: an instruction is at the exception-commit point this cycle.
REQ-004 SHALL have port commit_pc, input, 32: PC of the committing instruction.
REQ-005 SHALL have port commit_bd, input, 1: committing instruction is in a branch delay slot.
REQ-006 SHALL have port exc_flags, input, 7: {adel_if, ri, ov, sys, bp, adel_ld, ades}.
REQ-007 SHALL have port is_eret, input, 1: committing instruction is ERET.
REQ-008 SHALL have port mem_addr, input, 32: data address of committing load/store.
REQ-009 SHALL have port mem_stall, input, 1: pipeline held; CP0 ignores exception writes.
REQ-010 SHALL have ports allow_interrupt (1), interrupt_flag (8) and epc_address (32), all inputs from CP0.
REQ-011 SHALL have outputs exp_en, exp_badvaddr_en, exp_bd, exl_clean (1 each), exp_code (5), exp_badvaddr and exp_epc (32 each): the CP0 exception-write bundle.
REQ-012 SHALL have outputs flush (1), redirect_valid (1) and redirect_pc (32).
REQ-013 SHALL have output exc_count (32): count of taken exceptions and interrupts.

Function
REQ-014 SHALL implement FSM IDLE -> FLUSH -> REDIRECT -> IDLE.
REQ-015 In IDLE, detection SHALL occur when commit_valid && !mem_stall && (int_pending || |exc_flags || is_eret); the winning event, PC, BD and address SHALL be captured into registers and the FSM SHALL enter FLUSH next cycle.
REQ-016 int_pending SHALL be a register loaded every cycle with allow_interrupt && |interrupt_flag.
REQ-017 Priority SHALL be, highest first: int_pending (code 0), adel_if (4), ri (10), ov (12), sys (8), bp (9), adel_ld (4), ades (5), is_eret.
REQ-018 Captured EPC SHALL be commit_pc-4 when commit_bd=1 and commit_pc otherwise; exp_bd SHALL equal the captured commit_bd.
REQ-019 exp_badvaddr_en SHALL be 1 only for adel_if (exp_badvaddr=commit_pc) and for adel_ld/ades (exp_badvaddr=mem_addr).
REQ-020 In FLUSH, exp_en and flush SHALL be 1 with the captured bundle; FLUSH SHALL persist while mem_stall=1 and move to REDIRECT on the first cycle with mem_stall=0.
REQ-021 For ERET: exl_clean=1, exp_epc=epc_address sampled at detection, exp_code=0, exp_bd=0, exp_badvaddr_en=0; all other events use exl_clean=0.
REQ-022 In REDIRECT, redirect_valid SHALL be 1 for exactly one cycle with redirect_pc = 32'hBFC00380, or the captured epc_address for ERET; flush SHALL remain 1.
REQ-023 Outside FLUSH and REDIRECT, exp_en, flush and redirect_valid SHALL be 0; detections while not in IDLE SHALL be ignored.
REQ-024 Simultaneous interrupt and synchronous exception SHALL take the interrupt only, with EPC of the committing instruction.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, int_pending=0, all outputs 0 (redirect_pc=0, exc_count=0), aborting any FLUSH/REDIRECT in progress.
REQ-026 The first detection SHALL be possible on the first posedge after rst deasserts.

Configuration
REQ-027 With macro EXCEPTION_UNIT_PERF_COUNT_EN defined, exc_count SHALL increment by 1, wrapping 2^32-1 -> 0, on each FLUSH->REDIRECT transition excluding ERET.
REQ-028 Without EXCEPTION_UNIT_PERF_COUNT_EN, exc_count SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-029 A shared package exc_pkg SHALL hold the exc_code_t enum (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), the exc_state_t FSM enum and the vector constant EXC_VECTOR=32'hBFC00380.
REQ-030 Priority selection SHALL be a combinational sub-module exc_priority_enc that takes exc_flags, int_pending and is_eret and returns valid, code and kind; the FSM and registers SHALL remain in exception_unit.

Verification
REQ-031 ov at commit_pc=0x80001000, bd=0 -> one cycle later exp_en=1, exp_code=12, exp_epc=0x80001000; the next cycle redirect_valid=1 with redirect_pc=0xBFC00380.
REQ-032 ades, mem_addr=0x00000013, commit_pc=0x80000204, bd=1 -> exp_code=5, exp_badvaddr_en=1, exp_badvaddr=0x13, exp_epc=0x80000200, exp_bd=1.
REQ-033 allow_interrupt=1, interrupt_flag=8'h04 one cycle before a commit that also flags sys -> exp_code=0 taken and sys dropped.
REQ-034 ERET with epc_address=0x80002000 -> exl_clean=1, exp_epc=0x80002000, redirect_pc=0x80002000, exc_count unchanged.
REQ-035 mem_stall=1 for 3 cycles during FLUSH -> exp_en held 4 cycles, redirect_valid exactly one pulse after stall drops; rst low mid-FLUSH -> all outputs 0 at once.
